uart_tx_buffered: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the team's UART receiver, using the same baud and clock parameters.
- Accepts parallel bytes from user logic through a flag/ready handshake and serialises them LSB-first on tx.
- A one-byte holding register lets the next byte be queued while the current frame shifts out, so back-to-back frames have no idle gap.
- Sits between loopback/command logic and the FPGA tx pin.

---
 rtl/uart_tx_buffered.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1/8N2 UART transmitter, even parity bit when UART_TX_PARITY_EN is defined
module uart_tx_buffered #(
    parameter int UART_BPS  = 9600,
    parameter int CLK_FREQ  = 50000000,
    parameter int STOP_BITS = 1
) (
    input  logic       system_clk,
    input  logic       system_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       pi_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overrun
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BAUD_W = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t            state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_next;
    logic [3:0]        bit_cnt, bit_cnt_next;
    logic [7:0]        shift, shift_next;
    logic [7:0]        hold_data;
    logic              hold_valid, hold_valid_next;
    logic              bit_end, accept, load;
    logic              tx_next, done_next;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    // even parity of the byte entering the shifter, captured at load time
    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            parity_bit <= 1'b0;
        end else if (load) begin
            parity_bit <= ^hold_data;
        end
    end
`endif

    assign bit_end = (baud_cnt == BAUD_LAST);
    // pi_ready mirrors an empty holding register, so this is the write acceptance
    assign accept  = pi_flag && pi_ready;

    // next-state, shifter, counters and line value for the following cycle
    always_comb begin
        state_next = state;
        shift_next = shift;
        load       = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_cnt == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end && bit_cnt == STOP_LAST) begin
                    done_next = 1'b1;
                    if (hold_valid) begin
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) shift_next = hold_data;

        // load and accept are exclusive: load needs a full hold, accept an empty one
        hold_valid_next = hold_valid;
        if (load)   hold_valid_next = 1'b0;
        if (accept) hold_valid_next = 1'b1;

        if (state == IDLE)  baud_cnt_next = '0;
        else if (bit_end)   baud_cnt_next = '0;
        else                baud_cnt_next = baud_cnt + 1'b1;

        // bit_cnt counts data bits in DATA and stop bits in STOP, cleared on every state change
        if (state_next != state)                         bit_cnt_next = 4'd0;
        else if (bit_end && (state == DATA || state == STOP)) bit_cnt_next = bit_cnt + 4'd1;
        else                                             bit_cnt_next = bit_cnt;

        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_bit;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // state, datapath and registered outputs; the line follows the FSM by one cycle
    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= 4'd0;
            shift      <= 8'd0;
            hold_data  <= 8'd0;
            hold_valid <= 1'b0;
            pi_ready   <= 1'b1;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            if (accept) hold_data <= pi_data;
            hold_valid <= hold_valid_next;
            pi_ready   <= ~hold_valid_next;
            tx         <= tx_next;
            tx_busy    <= (state != IDLE);
            tx_done    <= done_next;
            overrun    <= pi_flag && !pi_ready;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered with a frame-level reference model
module tb_uart_tx_buffered;

    localparam int BAUD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
    localparam int NV  = 4;
`else
    localparam int PAR = 0;
    localparam int NV  = 6;
`endif
    localparam int NBITS  = 10 + PAR;
    localparam int FRAME1 = BAUD * (10 + PAR);
    localparam int FRAME2 = BAUD * (11 + PAR);

    logic       system_clk   = 1'b0;
    logic       system_rst_n = 1'b0;
    logic [7:0] pi_data  = 8'd0;
    logic       pi_flag  = 1'b0;
    logic       pi_ready, tx, tx_busy, tx_done, overrun;
    logic [7:0] pi_data2 = 8'd0;
    logic       pi_flag2 = 1'b0;
    logic       pi_ready2, tx2, tx_busy2, tx_done2, overrun2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_buffered #(.UART_BPS(100000), .CLK_FREQ(1000000), .STOP_BITS(1)) dut (
        .system_clk(system_clk), .system_rst_n(system_rst_n),
        .pi_data(pi_data), .pi_flag(pi_flag), .pi_ready(pi_ready),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .overrun(overrun)
    );

    uart_tx_buffered #(.UART_BPS(100000), .CLK_FREQ(1000000), .STOP_BITS(2)) dut2 (
        .system_clk(system_clk), .system_rst_n(system_rst_n),
        .pi_data(pi_data2), .pi_flag(pi_flag2), .pi_ready(pi_ready2),
        .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2), .overrun(overrun2)
    );

    always #5 system_clk = ~system_clk;
    always @(posedge system_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: frames as (start cycle, byte) records ----------------
    typedef struct { int start; logic [7:0] data; } frame_t;
    frame_t     frames[$];
    logic       m_hold_valid;
    logic [7:0] m_hold;
    logic       m_overrun;
    int         m_fsm_until;
    int         mk = 0;

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (PAR == 1 && i == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic m_reset();
        frames.delete();
        m_hold_valid = 1'b0;
        m_hold       = 8'd0;
        m_overrun    = 1'b0;
        m_fsm_until  = -100;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge system_clk);
            mk++;
            if (!system_rst_n) begin
                m_reset();
            end else begin
                logic   ready_before;
                frame_t f;
                ready_before = !m_hold_valid;
                m_overrun    = pi_flag && !ready_before;
                // shifter takes the held byte when the previous frame's FSM time is over
                if (m_hold_valid && (mk - 1 >= m_fsm_until)) begin
                    f.start = mk + 1;
                    f.data  = m_hold;
                    frames.push_back(f);
                    m_fsm_until  = mk + FRAME1 - 1;
                    m_hold_valid = 1'b0;
                end
                if (pi_flag && ready_before) begin
                    m_hold_valid = 1'b1;
                    m_hold       = pi_data;
                end
            end
        end
    end

    // per-cycle comparison of every output against the model
    initial begin
        forever begin
            logic e_tx, e_busy, e_done, e_ready, e_ovr;
            @(negedge system_clk);
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1; e_ovr = 1'b0;
            if (system_rst_n) begin
                while (frames.size() > 0 && frames[0].start + FRAME1 - 1 < mk) void'(frames.pop_front());
                for (int i = 0; i < frames.size(); i++) begin
                    if (frames[i].start <= mk && mk <= frames[i].start + FRAME1 - 1) begin
                        e_busy = 1'b1;
                        e_tx   = frame_bit(frames[i].data, (mk - frames[i].start) / BAUD);
                        if (mk == frames[i].start + FRAME1 - 1) e_done = 1'b1;
                    end
                end
                e_ready = !m_hold_valid;
                e_ovr   = m_overrun;
            end
            check("model_tx", tx, e_tx);
            check("model_tx_busy", tx_busy, e_busy);
            check("model_tx_done", tx_done, e_done);
            check("model_pi_ready", pi_ready, e_ready);
            check("model_overrun", overrun, e_ovr);
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct { logic [7:0] data; logic [10:0] bits; } vec_t;
    vec_t vecs[NV];

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge system_clk);
    endtask

    task automatic write_byte(input logic [7:0] d, output int n);
        pi_data = d;
        pi_flag = 1'b1;
        @(negedge system_clk);
        n = cyc;
        pi_flag = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 2000 && quiet < 3; i++) begin
            @(negedge system_clk);
            if (!tx_busy && pi_ready) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 3) begin
            failures++;
            $display("FAIL wait_idle timeout busy=%0b ready=%0b required idle", tx_busy, pi_ready);
        end
    endtask

    task automatic send_and_check(input vec_t v);
        int n, t0;
        wait_idle();
        write_byte(v.data, n);
        t0 = n + 2;
        wait_until(t0 - 1);
        check("latency_line_still_idle", tx, 1'b1);
        check("latency_busy_still_low", tx_busy, 1'b0);
        for (int i = 0; i < NBITS; i++) begin
            wait_until(t0 + i * BAUD + BAUD / 2);
            check($sformatf("frame_%02h_bit%0d", v.data, i), tx, v.bits[i]);
        end
        wait_until(t0 + FRAME1 - 1);
        check("tx_done_last_stop", tx_done, 1'b1);
        check("tx_busy_last_stop", tx_busy, 1'b1);
        wait_until(t0 + FRAME1);
        check("tx_busy_after_frame", tx_busy, 1'b0);
        check("tx_done_single_pulse", tx_done, 1'b0);
    endtask

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n, t0, busy_cnt, trail, dones;
        int done_at[$];

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h07, 11'b11000001110};
        vecs[1] = '{8'h55, 11'b10010101010};
        vecs[2] = '{8'hA3, 11'b10101000110};
        vecs[3] = '{8'h81, 11'b10100000010};
`else
        vecs[0] = '{8'h55, 11'b01010101010};
        vecs[1] = '{8'hA3, 11'b01101000110};
        vecs[2] = '{8'h0F, 11'b01000011110};
        vecs[3] = '{8'h00, 11'b01000000000};
        vecs[4] = '{8'hFF, 11'b01111111110};
        vecs[5] = '{8'h81, 11'b01100000010};
`endif

        // reset values
        repeat (3) @(negedge system_clk);
        check("reset_tx", tx, 1'b1);
        check("reset_pi_ready", pi_ready, 1'b1);
        check("reset_tx_busy", tx_busy, 1'b0);
        check("reset_tx_done", tx_done, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        #1 system_rst_n = 1'b1;

        // single frames from the table
        for (int i = 0; i < NV; i++) send_and_check(vecs[i]);

        // back-to-back frames, second byte written as soon as pi_ready returns
        wait_idle();
        write_byte(8'hA3, n);
        t0 = n + 2;
        wait_until(t0);
        busy_cnt = 0;
        done_at.delete();
        fork
            begin
                for (int t = t0; t <= t0 + 2 * FRAME1 + 4; t++) begin
                    wait_until(t);
                    if (tx_busy) busy_cnt++;
                    if (tx_done) done_at.push_back(t - t0 + 1);
                end
            end
            begin
                int w = 0;
                int n2;
                while (!pi_ready && w < 20) begin
                    @(negedge system_clk);
                    w++;
                end
                check("b2b_ready_returned", pi_ready, 1'b1);
                write_byte(8'h0F, n2);
            end
        join
        check("b2b_busy_cycles", busy_cnt, 2 * FRAME1);
        check("b2b_done_count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            check("b2b_done_first", done_at[0], FRAME1);
            check("b2b_done_second", done_at[1], 2 * FRAME1);
        end

        // overrun: third write while the holding register is full
        wait_idle();
        write_byte(8'h11, n);
        wait_until(n + 2);
        write_byte(8'h22, n);
        check("ovr_ready_low_after_22", pi_ready, 1'b0);
        write_byte(8'h33, n);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_hold_still_full", pi_ready, 1'b0);
        @(negedge system_clk);
        check("ovr_pulse_one_cycle", overrun, 1'b0);

        // reset during bit 4 of 8'hFF
        wait_idle();
        write_byte(8'hFF, n);
        t0 = n + 2;
        wait_until(t0 + 4 * BAUD + 3);
        check("rst_pre_busy", tx_busy, 1'b1);
        #2 system_rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1'b1);
        check("rst_async_busy", tx_busy, 1'b0);
        check("rst_async_ready", pi_ready, 1'b1);
        check("rst_async_done", tx_done, 1'b0);
        repeat (3) @(negedge system_clk);
        #1 system_rst_n = 1'b1;
        send_and_check(vecs[NV-1]);

        // two stop bits on the second instance
        @(negedge system_clk);
        pi_data2 = 8'h00;
        pi_flag2 = 1'b1;
        @(negedge system_clk);
        pi_flag2 = 1'b0;
        busy_cnt = 0; trail = 0; dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge system_clk);
            if (tx_busy2) begin
                busy_cnt++;
                if (tx2) trail++;
                else trail = 0;
            end
            if (tx_done2) dones++;
        end
        check("stop2_frame_len", busy_cnt, FRAME2);
        check("stop2_high_tail", trail, 2 * BAUD);
        check("stop2_done_count", dones, 1);

        // randomized traffic: dense writes first, then sparse ones with idle gaps
        for (int i = 0; i < 6000; i++) begin
            @(negedge system_clk);
            if (i < 3000) pi_flag = ($urandom_range(0, 19) == 0);
            else          pi_flag = ($urandom_range(0, 119) == 0);
            pi_data = 8'($urandom);
        end
        @(negedge system_clk);
        pi_flag = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
